// File: rtl/asynchronous_robot_control.sv
// Rotation-direction controller: synchronizes obstacle sensor Z and reverses direction on each filtered falling edge.
// Optional debounce filter is enabled by defining ROBOT_CTRL_DEBOUNCE_EN.
`default_nettype none

module asynchronous_robot_control #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic Z,
  output logic left,
  output logic right
);

  typedef enum logic [0:0] {
    ROT_LEFT  = 1'b0,
    ROT_RIGHT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   z_s;
  logic                   z_f;
  logic                   fall;
  state_t                 state;
  state_t                 state_next;

  // Synchronizer presets to "obstacle" so a clear sensor at reset release yields one toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Z};
    end
  end

  assign z_s = sync_q[SYNC_STAGES-1];

`ifdef ROBOT_CTRL_DEBOUNCE_EN
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      z_f <= 1'b1;
      cnt <= 8'd0;
    end else if (z_s == z_f) begin
      cnt <= 8'd0;
    end else if (cnt == CNT_MAX) begin
      z_f <= z_s;
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // Fall fires on the same edge that commits z_f from 1 to 0.
  assign fall = z_f & ~z_s & (cnt == CNT_MAX);
`else
  logic unused_debounce;

  assign unused_debounce = (DEBOUNCE_CYCLES == 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      z_f <= 1'b1;
    end else begin
      z_f <= z_s;
    end
  end

  assign fall = z_f & ~z_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ROT_LEFT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (fall) begin
      case (state)
        ROT_LEFT:  state_next = ROT_RIGHT;
        ROT_RIGHT: state_next = ROT_LEFT;
        default:   state_next = ROT_LEFT;
      endcase
    end
  end

  assign left  = (state == ROT_LEFT);
  assign right = (state == ROT_RIGHT);

endmodule

`default_nettype wire

// File: tb/tb_asynchronous_robot_control.sv
// Directed, table-driven bench for asynchronous_robot_control; expectations follow the build's debounce setting.
`timescale 1ns/1ps
`default_nettype none

module tb_asynchronous_robot_control;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;

`ifdef ROBOT_CTRL_DEBOUNCE_EN
  localparam int   LAT     = 5;     // SYNC_STAGES + DEBOUNCE_CYCLES - 1
  localparam int   MID_LOW = 3;     // leaves the filter counting when reset hits
  localparam logic G3      = 1'b0;  // 3-cycle low glitch filtered out
  localparam logic G4      = 1'b1;  // 4-cycle low pulse toggles
  localparam logic G1      = 1'b1;  // 1-cycle glitch filtered out, level kept
`else
  localparam int   LAT     = 2;
  localparam int   MID_LOW = 1;
  localparam logic G3      = 1'b1;
  localparam logic G4      = 1'b0;
  localparam logic G1      = 1'b1;  // 1-cycle glitch toggles back to left
`endif

  typedef struct {
    logic z;
    int   cycles;
    logic chk;
    logic exp_l;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic z   = 1'b1;
  logic left;
  logic right;

  int tests = 0;
  int fails = 0;

  vec_t vecs[13];

  asynchronous_robot_control #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .Z    (z),
    .left (left),
    .right(right)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lr(input string name, input logic exp_l);
    tests++;
    if (left !== exp_l || right !== ~exp_l) begin
      fails++;
      $display("FAIL %s: left=%b right=%b, expected left=%b right=%b",
               name, left, right, exp_l, ~exp_l);
    end
  endtask

  task automatic check_onehot(input int idx);
    tests++;
    if ((left ^ right) !== 1'b1) begin
      fails++;
      $display("FAIL vec[%0d] onehot: left=%b right=%b, expected exactly one high",
               idx, left, right);
    end
  endtask

  task automatic do_reset(input logic zv);
    rst = 1'b1;
    z   = zv;
    repeat (3) step();
    check_lr("reset_state", 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 10, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 10, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 10, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 10, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 10, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 10, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 10, 1'b1, 1'b0};
    vecs[7]  = '{1'b0,  3, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 10, 1'b1, G3};
    vecs[9]  = '{1'b0,  4, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 10, 1'b1, G4};
    vecs[11] = '{1'b0,  1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 10, 1'b1, G1};

    // Reset with obstacle present, then hold it.
    do_reset(1'b1);
    for (int i = 0; i < 50; i++) begin
      step();
      check_lr("hold_high", 1'b1);
    end

    // Exact toggle latency, then no further change while clear.
    z = 1'b0;
    for (int e = 1; e <= LAT + 10; e++) begin
      step();
      check_lr($sformatf("fall_latency_e%0d", e), (e <= LAT));
    end

    // Alternating levels and glitch pulses.
    do_reset(1'b1);
    for (int i = 0; i < 13; i++) begin
      z = vecs[i].z;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        step();
        check_onehot(i);
      end
      if (vecs[i].chk) begin
        check_lr($sformatf("vec[%0d]", i), vecs[i].exp_l);
      end
    end

    // Reset while in ROT_RIGHT with a falling edge still in flight.
    do_reset(1'b1);
    z = 1'b0;
    repeat (10) step();
    check_lr("mid_pre_right", 1'b0);
    z = 1'b1;
    repeat (10) step();
    check_lr("mid_rise_hold", 1'b0);
    z = 1'b0;
    repeat (MID_LOW) step();
    check_lr("mid_pending", 1'b0);
    rst = 1'b1;
    z   = 1'b1;
    step();
    check_lr("mid_rst", 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_lr("mid_discard", 1'b1);
    end

    // Releasing reset with the sensor clear gives exactly one toggle.
    do_reset(1'b0);
    repeat (10) step();
    check_lr("release_z0", 1'b0);
    repeat (10) step();
    check_lr("release_z0_once", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
